// File: rtl/adpll_lock_ctrl.sv
// ADPLL lock controller: programmable loop configuration plus an IDLE/LOAD/ACQ/LOCK
// sequencer that tracks phase-error magnitude to declare and drop lock.
module adpll_lock_ctrl #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pgm,
    input  logic       clr,
    input  logic [2:0] param_sel,
    input  logic [4:0] pgm_value,
    input  logic       start,
    input  logic       err_valid,
    input  logic [4:0] err_mag,
    output logic [4:0] kp,
    output logic [4:0] ki,
    output logic [4:0] dco_init,
    output logic [4:0] div_ratio,
    output logic [4:0] lock_thr,
    output logic       loop_en,
    output logic       dco_load,
    output logic       locked,
    output logic       acq_timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACQ = 2'd2, LOCK = 2'd3} state_t;

    localparam int IW = $clog2(LOCK_CNT + 1);
    localparam int OW = $clog2(UNLOCK_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [4:0] KP_DEF  = 5'd4;
    localparam logic [4:0] KI_DEF  = 5'd1;
    localparam logic [4:0] DCO_DEF = 5'd16;
    localparam logic [4:0] DIV_DEF = 5'd8;
    localparam logic [4:0] THR_DEF = 5'd2;

    // pgm_sync[2] is an extra delay stage used only for edge detection
    logic [2:0] pgm_sync;
    logic [1:0] clr_sync;
    logic       pgm_rise, clr_s;

    state_t          st, nxt;
    logic [IW-1:0]   in_cnt;
    logic [OW-1:0]   out_cnt;
    logic [TW-1:0]   acq_cyc;
    logic            err_in, err_out, lock_hit, tmo_hit, unlock_hit, tmo_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pgm_sync <= '0;
            clr_sync <= '0;
        end else begin
            pgm_sync <= {pgm_sync[1:0], pgm};
            clr_sync <= {clr_sync[0], clr};
        end
    end

    assign pgm_rise = pgm_sync[1] & ~pgm_sync[2];
    assign clr_s    = clr_sync[1];

    assign err_in     = err_valid && (err_mag <= lock_thr);
    assign err_out    = err_valid && (err_mag > lock_thr);
    assign lock_hit   = (in_cnt == IW'(LOCK_CNT));
    assign tmo_hit    = (acq_cyc == TW'(TIMEOUT - 1));
    assign unlock_hit = err_out && (out_cnt == OW'(UNLOCK_CNT - 1));

    always_comb begin
        nxt     = st;
        tmo_set = 1'b0;
        if (clr_s) begin
            nxt = IDLE;
        end else begin
            case (st)
                IDLE: if (start) nxt = LOAD;
                LOAD: nxt = ACQ;
                ACQ: begin
                    // lock takes precedence over a simultaneous timeout
                    if (lock_hit) begin
                        nxt = LOCK;
                    end else if (tmo_hit) begin
                        nxt     = LOAD;
                        tmo_set = 1'b1;
                    end
                end
                LOCK: if (unlock_hit) nxt = ACQ;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            loop_en     <= 1'b0;
            dco_load    <= 1'b0;
            locked      <= 1'b0;
            acq_timeout <= 1'b0;
        end else begin
            st       <= nxt;
            loop_en  <= (nxt == ACQ) || (nxt == LOCK);
            dco_load <= (nxt == LOAD);
            locked   <= (nxt == LOCK);
            if (clr_s || (st == IDLE && start))
                acq_timeout <= 1'b0;
            else if (tmo_set)
                acq_timeout <= 1'b1;
        end
    end

    // counters sit at zero outside their owning state, so entry always starts fresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt  <= '0;
            acq_cyc <= '0;
            out_cnt <= '0;
        end else begin
            if (clr_s || st != ACQ) begin
                in_cnt  <= '0;
                acq_cyc <= '0;
            end else begin
                if (err_in && !lock_hit)
                    in_cnt <= in_cnt + 1'b1;
                else if (err_out)
                    in_cnt <= '0;
                if (acq_cyc != TW'(TIMEOUT))
                    acq_cyc <= acq_cyc + 1'b1;
            end
            if (clr_s || st != LOCK || nxt != LOCK)
                out_cnt <= '0;
            else if (err_out && out_cnt != OW'(UNLOCK_CNT))
                out_cnt <= out_cnt + 1'b1;
            else if (err_in)
                out_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp        <= KP_DEF;
            ki        <= KI_DEF;
            dco_init  <= DCO_DEF;
            div_ratio <= DIV_DEF;
            lock_thr  <= THR_DEF;
        end else if (clr_s) begin
            kp        <= KP_DEF;
            ki        <= KI_DEF;
            dco_init  <= DCO_DEF;
            div_ratio <= DIV_DEF;
            lock_thr  <= THR_DEF;
        end else if (pgm_rise && st == IDLE) begin
            case (param_sel)
                3'd0: kp        <= pgm_value;
                3'd1: ki        <= pgm_value;
                3'd2: dco_init  <= pgm_value;
                3'd3: div_ratio <= (pgm_value == 5'd0) ? 5'd1 : pgm_value;
                3'd4: lock_thr  <= pgm_value;
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl: programming, lock/unlock, timeout retry, clr and reset.
module tb_adpll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst, pgm, clr, start, err_valid;
    logic [2:0] param_sel;
    logic [4:0] pgm_value, err_mag;
    logic [4:0] kp, ki, dco_init, div_ratio, lock_thr;
    logic       loop_en, dco_load, locked, acq_timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int dco_cnt = 0;
    logic dco_prev = 1'b0;

    always #5 clk = ~clk;

    adpll_lock_ctrl dut (
        .clk(clk), .rst(rst), .pgm(pgm), .clr(clr), .param_sel(param_sel),
        .pgm_value(pgm_value), .start(start), .err_valid(err_valid), .err_mag(err_mag),
        .kp(kp), .ki(ki), .dco_init(dco_init), .div_ratio(div_ratio), .lock_thr(lock_thr),
        .loop_en(loop_en), .dco_load(dco_load), .locked(locked),
        .acq_timeout(acq_timeout), .state(state)
    );

    // pulse counter and back-to-back guard for dco_load
    always @(negedge clk) begin
        if (dco_load) begin
            dco_cnt++;
            checks++;
            if (dco_prev) begin
                errors++;
                $display("FAIL dco_load_double got 1 after 1 exp 0");
            end
        end
        dco_prev <= dco_load;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] mag);
        err_valid = 1'b1;
        err_mag   = mag;
        tick();
        err_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; pgm = 0; clr = 0; start = 0; err_valid = 0;
        param_sel = 0; pgm_value = 0; err_mag = 0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_flags", {loop_en, dco_load, locked, acq_timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_kp", kp, 4);
        chk("rst_ki", ki, 1);
        chk("rst_dco_init", dco_init, 16);
        chk("rst_div_ratio", div_ratio, 8);
        chk("rst_lock_thr", lock_thr, 2);
        chk("rst_state_after", state, 0);
    endtask

    task automatic test_program;
        param_sel = 3'd2; pgm_value = 5'd9; pgm = 1'b1;
        tick(2);
        chk("pgm_dco_early", dco_init, 16);
        tick();
        chk("pgm_dco_init", dco_init, 9);
        pgm = 1'b0; tick(3);
        param_sel = 3'd3; pgm_value = 5'd0; pgm = 1'b1;
        tick(3);
        chk("pgm_div_zero", div_ratio, 1);
        pgm = 1'b0; tick(3);
        param_sel = 3'd5; pgm_value = 5'd31; pgm = 1'b1;
        tick(3);
        chk("pgm_sel5_ignored", {kp, ki, dco_init, div_ratio, lock_thr},
            {5'd4, 5'd1, 5'd9, 5'd1, 5'd2});
        pgm = 1'b0; tick(3);
    endtask

    task automatic test_lock;
        start = 1'b1; tick(); start = 1'b0;
        chk("lock_load_state", state, 1);
        chk("lock_load_pulse", {dco_load, loop_en}, 2'b10);
        tick();
        chk("lock_acq_state", state, 2);
        chk("lock_acq_flags", {dco_load, loop_en, locked}, 3'b010);
        // write attempt while in ACQ must be ignored
        param_sel = 3'd0; pgm_value = 5'd31; pgm = 1'b1;
        repeat (10) send(5'd1);
        send(5'd5);
        repeat (15) send(5'd1);
        chk("lock_restart_state", state, 2);
        send(5'd1);
        chk("lock_16th_state", state, 2);
        tick();
        chk("lock_state", state, 3);
        chk("lock_locked", locked, 1);
        chk("lock_dco_pulses", dco_cnt, 1);
        chk("lock_kp_ignored", kp, 4);
        pgm = 1'b0;
    endtask

    task automatic test_unlock;
        repeat (3) send(5'd7);
        send(5'd1);
        chk("unlock_3bad_state", state, 3);
        chk("unlock_3bad_locked", locked, 1);
        repeat (4) send(5'd7);
        chk("unlock_state", state, 2);
        chk("unlock_flags", {locked, loop_en}, 2'b01);
    endtask

    task automatic test_timeout;
        int n = 0;
        while (state == 2'd2 && n < 2000) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 1023);
        chk("tmo_state", state, 1);
        chk("tmo_flag", acq_timeout, 1);
        chk("tmo_dco_load", dco_load, 1);
        tick();
        chk("tmo_dco_pulses", dco_cnt, 2);
        chk("tmo_back_acq", state, 2);
        chk("tmo_sticky", acq_timeout, 1);
    endtask

    task automatic test_clr;
        repeat (16) send(5'd2);
        tick();
        chk("clr_pre_lock", state, 3);
        clr = 1'b1;
        tick(2);
        chk("clr_sync_delay", state, 3);
        tick();
        chk("clr_state", state, 0);
        chk("clr_flags", {locked, loop_en, acq_timeout}, 0);
        chk("clr_defaults", {kp, ki, dco_init, div_ratio, lock_thr},
            {5'd4, 5'd1, 5'd16, 5'd8, 5'd2});
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("clr_start_ignored", state, 0);
        chk("clr_no_pulse", dco_cnt, 2);
        clr = 1'b0;
        tick(3);
    endtask

    task automatic test_rst_abort;
        start = 1'b1; tick(); start = 1'b0;
        chk("abort_load", state, 1);
        tick();
        chk("abort_acq", state, 2);
        rst = 1'b1; #1;
        chk("abort_state", state, 0);
        chk("abort_flags", {dco_load, loop_en, locked}, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk("abort_idle", state, 0);
        chk("abort_pulses", dco_cnt, 3);
    endtask

    initial begin
        test_reset();
        test_program();
        test_lock();
        test_unlock();
        test_timeout();
        test_clr();
        test_rst_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: consecutive in-threshold error samples needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_CNT, default 4: consecutive out-of-threshold samples needed to drop lock.
REQ-003 SHALL have parameter TIMEOUT, default 1023: maximum clk cycles spent in ACQ before a retry.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pgm  input  1  asynchronous level; programs the parameter selected by param_sel on its rising edge.
REQ-007 clr  input  1  asynchronous level; restores defaults and aborts operation while high.
REQ-008 param_sel  input  3  parameter select: 0 kp, 1 ki, 2 dco_init, 3 div_ratio, 4 lock_thr, 5-7 unused.
REQ-009 pgm_value  input  5  unsigned value to program.
REQ-010 start  input  1  synchronous one-cycle request to begin acquisition.
REQ-011 err_valid  input  1  qualifies err_mag for one cycle.
REQ-012 err_mag  input  5  unsigned phase-error magnitude from the TDC path.
REQ-013 kp, ki, dco_init, div_ratio, lock_thr  output  5 each  registered loop configuration.
REQ-014 loop_en  output  1  enables filter/DCO update.
REQ-015 dco_load  output  1  one-cycle pulse; loads dco_init into the DCO.
REQ-016 locked  output  1  lock indication.
REQ-017 acq_timeout  output  1  sticky flag: an ACQ timeout has occurred.
REQ-018 state  output  2  current FSM state: IDLE=0, LOAD=1, ACQ=2, LOCK=3.

Function
REQ-019 pgm and clr SHALL each pass through a two-flop synchronizer before use.
REQ-020 A write SHALL occur on the synchronized rising edge of pgm.
- The target register SHALL update on the 3rd clk edge after pgm rises.
REQ-021 Writes SHALL take effect only in IDLE; writes in other states, or with param_sel 5-7, SHALL be ignored.
REQ-022 A write of 0 to div_ratio SHALL store 1.
REQ-023 Synchronized clr high SHALL, each cycle it is high:
- force IDLE;
- restore parameter defaults kp=4, ki=1, dco_init=16, div_ratio=8, lock_thr=2;
- clear all counters and acq_timeout.
REQ-024 clr SHALL take priority over pgm, start and all FSM transitions in the same cycle.
REQ-025 IDLE: start=1 SHALL go to LOAD next cycle and clear acq_timeout; start in any other state SHALL be ignored.
REQ-026 LOAD: lasts exactly 1 cycle, dco_load=1, loop_en=0; then goes to ACQ.
REQ-027 ACQ behaviour:
- loop_en=1;
- the in-threshold counter SHALL increment on err_valid with err_mag <= lock_thr, and clear on err_valid with err_mag > lock_thr;
- cycles without err_valid SHALL leave the counter unchanged.
REQ-028 ACQ SHALL go to LOCK on the cycle after the in-threshold counter reaches LOCK_CNT; locked=1 while in LOCK.
REQ-029 The ACQ cycle counter SHALL start at 0 on ACQ entry.
- On reaching TIMEOUT without lock: set acq_timeout, go to LOAD (retry with a fresh dco_load pulse).
- If lock and timeout qualify in the same cycle, lock SHALL win.
REQ-030 LOCK: loop_en=1.
- The out-of-threshold counter counts consecutive err_valid samples with err_mag > lock_thr; an in-threshold sample clears it.
- On reaching UNLOCK_CNT: go to ACQ, with locked=0 and all counters cleared on entry.
REQ-031 All counters SHALL saturate at their terminal value and never wrap.
REQ-032 All outputs SHALL be registered; dco_load SHALL never be high for two consecutive cycles.

Reset
REQ-033 rst high SHALL immediately force:
- state=IDLE, loop_en=0, dco_load=0, locked=0, acq_timeout=0;
- counters and synchronizers to 0;
- parameters to the REQ-023 defaults.
REQ-034 Operation SHALL resume on the first clk edge after rst deasserts; rst mid-ACQ/LOCK SHALL abort with no dco_load pulse.

Verification
REQ-035 Assert and release rst -> outputs are kp=4, ki=1, dco_init=16, div_ratio=8, lock_thr=2, state=0, all flags 0.
REQ-036 Programming:
- IDLE, param_sel=2, pgm_value=9, pgm rise -> dco_init=9 three cycles later;
- param_sel=3, value 0 -> div_ratio=1;
- a pgm write while in ACQ -> no change.
REQ-037 Lock acquisition:
- start, then 16 err_valid samples with err_mag=1 (lock_thr=2) -> dco_load pulses once, LOCK reached, locked=1;
- a sample with err_mag=5 at count 10 restarts the count.
REQ-038 In LOCK, 4 consecutive samples with err_mag=7 -> state=ACQ, locked=0; 3 bad samples then 1 good -> stays LOCK.
REQ-039 With no err_valid for 1023 cycles in ACQ -> acq_timeout=1, state=LOAD, second dco_load pulse.
REQ-040 clr raised mid-LOCK -> within 3 cycles state=IDLE, locked=0, loop_en=0, defaults restored; start with clr high -> ignored.
